// File: rtl/clock_count1.sv
// clock_count1: hh:mm:ss time-of-day counter.
// A clk prescaler generates the one-second tick that drives the cascade.
module clock_count1 #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned SEC_MAX       = 59,
   parameter int unsigned MIN_MAX       = 59,
   parameter int unsigned HR_MAX        = 23
) (
   input  logic       clk,
   input  logic       rst,
   output logic [5:0] cn,
   output logic [5:0] min,
   output logic [5:0] hr
);

   localparam int unsigned PW =
      (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [5:0]    S_MAX    = 6'(SEC_MAX);
   localparam logic [5:0]    M_MAX    = 6'(MIN_MAX);
   localparam logic [5:0]    H_MAX    = 6'(HR_MAX);

   logic [PW-1:0] pre;
   logic          tick;
   logic          sec_wrap;
   logic          min_wrap;
   logic          hr_wrap;

   assign tick     = (pre == PRE_LAST);
   // >= rather than == so a stray out-of-range value recovers to 0
   assign sec_wrap = (cn  >= S_MAX);
   assign min_wrap = (min >= M_MAX);
   assign hr_wrap  = (hr  >= H_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
         cn  <= '0;
         min <= '0;
         hr  <= '0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            cn <= sec_wrap ? 6'd0 : cn + 6'd1;
            if (sec_wrap) begin
               min <= min_wrap ? 6'd0 : min + 6'd1;
               if (min_wrap)
                  hr <= hr_wrap ? 6'd0 : hr + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_count1.sv
// tb_clock_count1: vector table, hand sequences and randomized resets
// checked against an elapsed-clock arithmetic model.
module tb_clock_count1;

   logic       clk = 1'b0;
   logic       rst_a = 1'b0;
   logic       rst_b = 1'b0;
   logic [5:0] cn_a, min_a, hr_a;
   logic [5:0] cn_b, min_b, hr_b;

   int cmp_n = 0;
   int bad_n = 0;

   always #5 clk = ~clk;

   clock_count1 dut_a (
      .clk (clk),
      .rst (rst_a),
      .cn  (cn_a),
      .min (min_a),
      .hr  (hr_a)
   );

   clock_count1 #(
      .TICKS_PER_SEC (4),
      .SEC_MAX       (5),
      .MIN_MAX       (3),
      .HR_MAX        (2)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .cn  (cn_b),
      .min (min_b),
      .hr  (hr_b)
   );

   typedef struct {
      int         clocks;
      logic [5:0] hr;
      logic [5:0] min;
      logic [5:0] cn;
   } vec_t;

   vec_t tbl [5];

   // Expected {hr,min,cn} after n edges since reset release
   function automatic logic [17:0] ref_time(int n, int t,
                                            int s, int m, int h);
      int secs;
      int c;
      int mi;
      int hh;
      secs = n / t;
      c    = secs % (s + 1);
      mi   = (secs / (s + 1)) % (m + 1);
      hh   = (secs / ((s + 1) * (m + 1))) % (h + 1);
      return {6'(hh), 6'(mi), 6'(c)};
   endfunction

   task automatic chk(string nm, logic [17:0] act, logic [17:0] exp);
      cmp_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got hr=%0d min=%0d cn=%0d, want hr=%0d min=%0d cn=%0d",
                  nm, act[17:12], act[11:6], act[5:0],
                  exp[17:12], exp[11:6], exp[5:0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;

      tbl[0] = '{10,    6'd0,  6'd0,  6'd10};
      tbl[1] = '{60,    6'd0,  6'd1,  6'd0};
      tbl[2] = '{3600,  6'd1,  6'd0,  6'd0};
      tbl[3] = '{86399, 6'd23, 6'd59, 6'd59};
      tbl[4] = '{86400, 6'd0,  6'd0,  6'd0};

      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      repeat (2) begin
         step();
         chk("rst_hold_a", {hr_a, min_a, cn_a}, 18'd0);
         chk("rst_hold_b", {hr_b, min_b, cn_b}, 18'd0);
      end

      // Full day on the default clock, model checked on every edge
      rst_a = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         while (n < tbl[i].clocks) begin
            step();
            n++;
            chk("day_model", {hr_a, min_a, cn_a},
                ref_time(n, 1, 59, 59, 23));
         end
         chk($sformatf("vec%0d_%0dclk", i, tbl[i].clocks),
             {hr_a, min_a, cn_a}, {tbl[i].hr, tbl[i].min, tbl[i].cn});
      end

      // Mid-count asynchronous reset
      rst_a = 1'b0;
      #1;
      rst_a = 1'b1;
      repeat (25) step();
      chk("count25", {hr_a, min_a, cn_a}, {6'd0, 6'd0, 6'd25});
      rst_a = 1'b0;
      #2;
      chk("async_clear", {hr_a, min_a, cn_a}, 18'd0);
      rst_a = 1'b1;
      step();
      chk("after_rst_1clk", {hr_a, min_a, cn_a}, {6'd0, 6'd0, 6'd1});

      // Prescaled instance: 8 clocks give two seconds
      rst_b = 1'b1;
      n = 0;
      repeat (8) begin
         step();
         n++;
         chk("t4_model", {hr_b, min_b, cn_b}, ref_time(n, 4, 5, 3, 2));
      end
      chk("t4_8clk", {hr_b, min_b, cn_b}, {6'd0, 6'd0, 6'd2});

      // Random run with sporadic asynchronous resets
      for (int k = 0; k < 3000; k++) begin
         step();
         n++;
         chk("rand_model", {hr_b, min_b, cn_b}, ref_time(n, 4, 5, 3, 2));
         if ($urandom_range(0, 59) == 0) begin
            rst_b = 1'b0;
            #1;
            chk("rand_async_clr", {hr_b, min_b, cn_b}, 18'd0);
            n = 0;
            if ($urandom_range(0, 1) == 1) begin
               step();
               chk("rand_rst_hold", {hr_b, min_b, cn_b}, 18'd0);
            end
            rst_b = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_n, bad_n);
      $finish;
   end

endmodule

// File: doc/clock_count1.md
CLOCK_COUNT1 -- requirements
Module: clock_count1

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 1, number of clk cycles per one-second advance; legal range 1..2^20.
REQ-002 Parameter: SEC_MAX, default 59, terminal value of the seconds counter.
REQ-003 Parameter: MIN_MAX, default 59, terminal value of the minutes counter.
REQ-004 Parameter: HR_MAX, default 23, terminal value of the hours counter.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-low; rst=0 forces reset, rst=1 means run.
REQ-007 Port: cn  output  6  seconds count, unsigned binary, 0..SEC_MAX.
REQ-008 Port: min  output  6  minutes count, unsigned binary, 0..MIN_MAX.
REQ-009 Port: hr  output  6  hours count, unsigned binary, 0..HR_MAX.

Function
REQ-010 The block SHALL contain an internal prescaler counting 0..TICKS_PER_SEC-1, advancing once per clk edge while rst=1.
REQ-011 A one-cycle internal tick SHALL assert on the edge where the prescaler equals TICKS_PER_SEC-1; the prescaler then wraps to 0 on that same edge.
REQ-012 With TICKS_PER_SEC=1, tick SHALL be asserted on every clk edge, so cn advances once per clock.
REQ-013 On tick, cn SHALL increment by 1; if cn equals SEC_MAX, cn SHALL wrap to 0 instead.
REQ-014 min SHALL increment by 1 only on a tick where cn equals SEC_MAX; if min also equals MIN_MAX, min SHALL wrap to 0.
REQ-015 hr SHALL increment by 1 only on a tick where cn=SEC_MAX and min=MIN_MAX; if hr also equals HR_MAX, hr SHALL wrap to 0.
REQ-016 At 23:59:59 the next tick SHALL produce hr=0, min=0, cn=0 on the same edge (simultaneous cascaded wrap).
REQ-017 All outputs SHALL be registered (driven directly by flops); there is no combinational path from inputs to outputs.
REQ-018 Outputs SHALL change only on a tick edge or on reset; no output changes on non-tick edges.
REQ-019 Latency from a tick edge to the updated cn/min/hr value SHALL be zero additional cycles (visible immediately after that edge).
REQ-020 Counters SHALL never hold values above their MAX parameter; an out-of-range value SHALL wrap to 0 on the next tick.
REQ-021 Parameter values SHALL satisfy SEC_MAX, MIN_MAX, HR_MAX <= 63, so each fits in 6 bits.

Reset
REQ-022 While rst=0, cn, min, hr and the prescaler SHALL be 0, applied immediately without waiting for a clk edge.
REQ-023 Reset assertion mid-count SHALL clear all state asynchronously, discarding any pending tick.
REQ-024 After rst rises to 1, the first clk edge SHALL count as prescaler cycle 0; with TICKS_PER_SEC=1, the first edge yields cn=1.
REQ-025 Output values before the first reset assertion are undefined; every bench SHALL apply reset first.

Verification
REQ-026 Hold rst=0 for 2 clocks -> cn=0, min=0, hr=0 throughout.
REQ-027 Release rst, then apply 10 clocks (TICKS_PER_SEC=1) -> cn=10, min=0, hr=0.
REQ-028 Release rst, then apply 60 clocks -> cn=0, min=1, hr=0; after 3600 clocks -> cn=0, min=0, hr=1.
REQ-029 Release rst, then apply 86399 clocks -> hr=23, min=59, cn=59; one more clock -> hr=0, min=0, cn=0.
REQ-030 Count to cn=25, then drive rst=0 between clock edges -> all outputs 0 before the next edge; release rst, one clock -> cn=1.
REQ-031 With TICKS_PER_SEC=4, apply 8 clocks after reset -> cn=2; cn holds steady on the 3 non-tick edges within each group of 4.
